seq_loop_monitor: RTL and testbench

SEQ_LOOP_MONITOR -- requirements
Module: seq_loop_monitor

---
 rtl/seq_loop_monitor_if.sv | 53 +++++
 rtl/seq_loop_monitor.sv | 173 +++++++++++++++++
 tb/tb_seq_loop_monitor.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_loop_monitor_if.sv
// Bundles the observed HLS FSM state, the loop description and the monitor
// results into one port.
//   master : drives the observed state, loop description and finish;
//            reads the monitor results.
//   slave  : the monitor itself, with the directions reversed.
`timescale 1ns/1ps
interface seq_loop_monitor_if #(
  parameter int unsigned FSM_WIDTH = 2,
  parameter int unsigned CNT_W     = 32
);
  // Observed FSM and loop description
  logic [FSM_WIDTH-1:0] cur_state;
  logic                 pre_states_valid;
  logic [FSM_WIDTH-1:0] pre_loop_state0;
  logic [2:0]           quit_states_valid;
  logic [FSM_WIDTH-1:0] quit_loop_state0;
  logic [FSM_WIDTH-1:0] quit_loop_state1;
  logic [FSM_WIDTH-1:0] quit_loop_state2;
  logic [FSM_WIDTH-1:0] loop_quit_state;
  logic [FSM_WIDTH-1:0] iter_start_state;
  logic                 iter_end_states_valid;
  logic [FSM_WIDTH-1:0] iter_end_state0;
  logic                 one_state_loop;
  logic                 finish;

  // Monitor results
  logic                 loop_active;
  logic                 loop_start;
  logic                 iter_done;
  logic                 loop_done;
  logic [CNT_W-1:0]     iter_count;
  logic [CNT_W-1:0]     trip_count;
  logic                 hang;
  logic                 finished;

  modport master (
    output cur_state, pre_states_valid, pre_loop_state0, quit_states_valid,
           quit_loop_state0, quit_loop_state1, quit_loop_state2,
           loop_quit_state, iter_start_state, iter_end_states_valid,
           iter_end_state0, one_state_loop, finish,
    input  loop_active, loop_start, iter_done, loop_done, iter_count,
           trip_count, hang, finished
  );

  modport slave (
    input  cur_state, pre_states_valid, pre_loop_state0, quit_states_valid,
           quit_loop_state0, quit_loop_state1, quit_loop_state2,
           loop_quit_state, iter_start_state, iter_end_states_valid,
           iter_end_state0, one_state_loop, finish,
    output loop_active, loop_start, iter_done, loop_done, iter_count,
           trip_count, hang, finished
  );
endinterface

// File: rtl/seq_loop_monitor.sv
// Watches the state of an HLS-generated FSM and reports loop entry, iteration
// completion, loop exit, trip count, watchdog hang and design finish.
// Ports:
//   clock  : sole clock, rising edge
//   reset  : synchronous, active-high; returns everything to IDLE / zero
//   bus    : seq_loop_monitor_if.slave -- observed FSM state, loop
//            description, finish in; registered monitor results out
// All results reflect the inputs of cycle t at cycle t+1.
`timescale 1ns/1ps
module seq_loop_monitor #(
  parameter int unsigned FSM_WIDTH = 2,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clock,
  input  logic              reset,
  seq_loop_monitor_if.slave bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, HUNG, FIN} mon_state_e;

  mon_state_e           state_q, state_d;
  logic [FSM_WIDTH-1:0] prev_state_q;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [CNT_W-1:0]     iter_cnt_q, iter_cnt_d;
  logic [CNT_W-1:0]     trip_q, trip_d;
  logic                 loop_active_q, loop_active_d;
  logic                 loop_start_q, loop_start_d;
  logic                 iter_done_q, iter_done_d;
  logic                 loop_done_q, loop_done_d;
  logic                 hang_q, hang_d;
  logic                 finished_q, finished_d;

  logic                 entry_c, quit_hit_c, exit_c, iter_c, timeout_c;
  logic [CNT_W-1:0]     iter_inc_c;
  logic [WD_W-1:0]      wd_inc_c;

  // Loop entry: iteration start reached from the expected predecessor
  assign entry_c = (bus.cur_state == bus.iter_start_state) &&
                   (!bus.pre_states_valid || (prev_state_q == bus.pre_loop_state0));

  // Exit needs a predecessor among the enabled quit states (any, if none enabled)
  assign quit_hit_c = (bus.quit_states_valid == 3'b000) ||
                      (bus.quit_states_valid[0] && (prev_state_q == bus.quit_loop_state0)) ||
                      (bus.quit_states_valid[1] && (prev_state_q == bus.quit_loop_state1)) ||
                      (bus.quit_states_valid[2] && (prev_state_q == bus.quit_loop_state2));
  assign exit_c = (bus.cur_state == bus.loop_quit_state) && quit_hit_c;

  // Completion: leaving the end state (so stalls count once), or every
  // start-state cycle for a single-state body
  always_comb begin
    iter_c = 1'b0;
    if (bus.one_state_loop) begin
      iter_c = (bus.cur_state == bus.iter_start_state);
    end else if (bus.iter_end_states_valid) begin
      iter_c = (prev_state_q == bus.iter_end_state0) &&
               (bus.cur_state != bus.iter_end_state0);
    end
  end

  assign iter_inc_c = (iter_cnt_q == {CNT_W{1'b1}}) ? iter_cnt_q : iter_cnt_q + CNT_W'(1);
  assign wd_inc_c   = wd_q + WD_W'(1);
  assign timeout_c  = !iter_c && (wd_inc_c >= WD_W'(TIMEOUT));

  // Next state and next registered outputs; FIN > HUNG > exit > entry
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    iter_cnt_d   = iter_cnt_q;
    trip_d       = trip_q;
    hang_d       = hang_q;
    finished_d   = finished_q;
    loop_start_d = 1'b0;
    iter_done_d  = 1'b0;
    loop_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.finish) begin
          state_d    = FIN;
          finished_d = 1'b1;
        end else if (entry_c) begin
          state_d      = RUN;
          loop_start_d = 1'b1;
          wd_d         = '0;
          // Single-state body: the entry cycle is itself an iteration
          if (bus.one_state_loop) begin
            iter_done_d = 1'b1;
            iter_cnt_d  = CNT_W'(1);
          end else begin
            iter_cnt_d  = '0;
          end
        end
      end
      RUN: begin
        if (bus.finish) begin
          state_d    = FIN;
          finished_d = 1'b1;
        end else if (timeout_c) begin
          state_d = HUNG;
          hang_d  = 1'b1;
          wd_d    = wd_inc_c;
        end else begin
          if (iter_c) begin
            iter_done_d = 1'b1;
            iter_cnt_d  = iter_inc_c;
            wd_d        = '0;
          end else begin
            wd_d = wd_inc_c;
          end
          if (exit_c) begin
            state_d     = IDLE;
            loop_done_d = 1'b1;
            trip_d      = iter_c ? iter_inc_c : iter_cnt_q;
          end
        end
      end
      HUNG: begin
        if (bus.finish) begin
          state_d    = FIN;
          finished_d = 1'b1;
        end
      end
      FIN: begin
        state_d = FIN;
      end
      default: state_d = IDLE;
    endcase

    loop_active_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_state_q  <= '0;
      wd_q          <= '0;
      iter_cnt_q    <= '0;
      trip_q        <= '0;
      loop_active_q <= 1'b0;
      loop_start_q  <= 1'b0;
      iter_done_q   <= 1'b0;
      loop_done_q   <= 1'b0;
      hang_q        <= 1'b0;
      finished_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_state_q  <= bus.cur_state;
      wd_q          <= wd_d;
      iter_cnt_q    <= iter_cnt_d;
      trip_q        <= trip_d;
      loop_active_q <= loop_active_d;
      loop_start_q  <= loop_start_d;
      iter_done_q   <= iter_done_d;
      loop_done_q   <= loop_done_d;
      hang_q        <= hang_d;
      finished_q    <= finished_d;
    end
  end

  assign bus.loop_active = loop_active_q;
  assign bus.loop_start  = loop_start_q;
  assign bus.iter_done   = iter_done_q;
  assign bus.loop_done   = loop_done_q;
  assign bus.iter_count  = iter_cnt_q;
  assign bus.trip_count  = trip_q;
  assign bus.hang        = hang_q;
  assign bus.finished    = finished_q;

endmodule

// File: tb/tb_seq_loop_monitor.sv
// Directed bench for seq_loop_monitor: each task drives one scenario and
// compares the registered results one cycle after each observed state.
`timescale 1ns/1ps
module tb_seq_loop_monitor;
  localparam int unsigned FSM_WIDTH = 2;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned TIMEOUT   = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_loop_monitor_if #(.FSM_WIDTH(FSM_WIDTH), .CNT_W(CNT_W)) bus ();

  seq_loop_monitor #(.FSM_WIDTH(FSM_WIDTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Present one observed state for one cycle; results are visible on return
  task automatic step(input logic [1:0] v);
    bus.cur_state = v;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    bus.cur_state = 2'd0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // start=1, end=2, quit=3 reached from quit0=2, pre=0
  task automatic cfg_multi();
    bus.pre_states_valid      = 1'b1;
    bus.pre_loop_state0       = 2'd0;
    bus.quit_states_valid     = 3'b001;
    bus.quit_loop_state0      = 2'd2;
    bus.quit_loop_state1      = 2'd0;
    bus.quit_loop_state2      = 2'd0;
    bus.loop_quit_state       = 2'd3;
    bus.iter_start_state      = 2'd1;
    bus.iter_end_states_valid = 1'b1;
    bus.iter_end_state0       = 2'd2;
    bus.one_state_loop        = 1'b0;
    bus.finish                = 1'b0;
  endtask

  task automatic test_reset();
    cfg_multi();
    apply_reset(3);
    checks++;
    if ({bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done, bus.hang, bus.finished} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000",
               {bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done, bus.hang, bus.finished});
    end
    checks++;
    if (bus.iter_count !== 32'd0 || bus.trip_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counts iter %0d trip %0d exp 0 0", bus.iter_count, bus.trip_count);
    end
  endtask

  // flags = {loop_active, loop_start, iter_done, loop_done}
  task automatic test_multi_state();
    logic [1:0] seq [8]  = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    logic [3:0] flg [8]  = '{4'b0000, 4'b1100, 4'b1000, 4'b1010, 4'b1000, 4'b1010, 4'b1000, 4'b0011};
    int         cnt [8]  = '{0, 0, 0, 1, 1, 2, 2, 3};
    cfg_multi();
    apply_reset(1);
    for (int i = 0; i < 8; i++) begin
      step(seq[i]);
      checks++;
      if ({bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done} !== flg[i] ||
          bus.iter_count !== 32'(cnt[i])) begin
        errors++;
        $display("FAIL multi step %0d flags %b cnt %0d exp %b %0d", i,
                 {bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done},
                 bus.iter_count, flg[i], cnt[i]);
      end
    end
    checks++;
    if (bus.trip_count !== 32'd3) begin
      errors++;
      $display("FAIL multi_trip got %0d exp 3", bus.trip_count);
    end
    step(2'd0);
    checks++;
    if (bus.iter_count !== 32'd3 || bus.loop_done !== 1'b0 || bus.loop_active !== 1'b0) begin
      errors++;
      $display("FAIL multi_hold cnt %0d ld %b la %b exp 3 0 0", bus.iter_count, bus.loop_done, bus.loop_active);
    end
  endtask

  task automatic test_single_state();
    logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic [3:0] flg [6] = '{4'b0000, 4'b1110, 4'b1010, 4'b1010, 4'b1010, 4'b0001};
    int         cnt [6] = '{0, 1, 2, 3, 4, 4};
    cfg_multi();
    bus.pre_states_valid      = 1'b0;
    bus.quit_states_valid     = 3'b000;
    bus.loop_quit_state       = 2'd2;
    bus.iter_end_states_valid = 1'b0;
    bus.one_state_loop        = 1'b1;
    apply_reset(1);
    for (int i = 0; i < 6; i++) begin
      step(seq[i]);
      checks++;
      if ({bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done} !== flg[i] ||
          bus.iter_count !== 32'(cnt[i])) begin
        errors++;
        $display("FAIL single step %0d flags %b cnt %0d exp %b %0d", i,
                 {bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done},
                 bus.iter_count, flg[i], cnt[i]);
      end
    end
    checks++;
    if (bus.trip_count !== 32'd4) begin
      errors++;
      $display("FAIL single_trip got %0d exp 4", bus.trip_count);
    end
  endtask

  // Re-entry the cycle after exit, with pre-state qualification disabled
  task automatic test_back_to_back();
    logic [1:0] seq  [10] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    logic [3:0] flg  [10] = '{4'b1100, 4'b1000, 4'b1010, 4'b1000, 4'b0011,
                              4'b1100, 4'b1000, 4'b1010, 4'b1000, 4'b0011};
    int         cnt  [10] = '{0, 0, 1, 1, 2, 0, 0, 1, 1, 2};
    int         trip [10] = '{0, 0, 0, 0, 2, 2, 2, 2, 2, 2};
    cfg_multi();
    bus.pre_states_valid = 1'b0;
    apply_reset(1);
    for (int i = 0; i < 10; i++) begin
      step(seq[i]);
      checks++;
      if ({bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done} !== flg[i] ||
          bus.iter_count !== 32'(cnt[i]) || bus.trip_count !== 32'(trip[i])) begin
        errors++;
        $display("FAIL b2b step %0d flags %b cnt %0d trip %0d exp %b %0d %0d", i,
                 {bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done},
                 bus.iter_count, bus.trip_count, flg[i], cnt[i], trip[i]);
      end
    end
  endtask

  // Quit state from a non-enabled predecessor is ignored; end-state stall counts once
  task automatic test_quit_filter();
    logic [1:0] seq [7] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [3:0] flg [7] = '{4'b0000, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1010};
    int         cnt [7] = '{0, 0, 0, 0, 0, 0, 1};
    cfg_multi();
    apply_reset(1);
    for (int i = 0; i < 7; i++) begin
      step(seq[i]);
      checks++;
      if ({bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done} !== flg[i] ||
          bus.iter_count !== 32'(cnt[i])) begin
        errors++;
        $display("FAIL quit step %0d flags %b cnt %0d exp %b %0d", i,
                 {bus.loop_active, bus.loop_start, bus.iter_done, bus.loop_done},
                 bus.iter_count, flg[i], cnt[i]);
      end
    end
    bus.quit_states_valid = 3'b100;
    bus.quit_loop_state2  = 2'd1;
    step(2'd3);
    checks++;
    if ({bus.loop_active, bus.loop_done} !== 2'b01 || bus.trip_count !== 32'd1) begin
      errors++;
      $display("FAIL quit2_exit la %b ld %b trip %0d exp 0 1 1", bus.loop_active, bus.loop_done, bus.trip_count);
    end
  endtask

  task automatic test_hang();
    cfg_multi();
    apply_reset(1);
    step(2'd0);
    step(2'd1);
    checks++;
    if (bus.loop_start !== 1'b1 || bus.loop_active !== 1'b1) begin
      errors++;
      $display("FAIL hang_entry ls %b la %b exp 1 1", bus.loop_start, bus.loop_active);
    end
    for (int k = 1; k <= 8; k++) begin
      step(2'd1);
      checks++;
      if ({bus.loop_active, bus.hang} !== ((k < 8) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL hang_run cycle %0d la,hang %b%b exp %s", k, bus.loop_active, bus.hang,
                 (k < 8) ? "10" : "01");
      end
    end
    step(2'd2);
    step(2'd3);
    checks++;
    if (bus.hang !== 1'b1 || bus.loop_done !== 1'b0 || bus.loop_active !== 1'b0) begin
      errors++;
      $display("FAIL hang_sticky hang %b ld %b la %b exp 1 0 0", bus.hang, bus.loop_done, bus.loop_active);
    end
    apply_reset(1);
    checks++;
    if (bus.hang !== 1'b0) begin
      errors++;
      $display("FAIL hang_reset got %b exp 0", bus.hang);
    end
  endtask

  task automatic test_finish();
    logic [1:0] seq [6]  = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    logic [1:0] post [3] = '{2'd1, 2'd2, 2'd3};
    cfg_multi();
    apply_reset(1);
    for (int i = 0; i < 6; i++) step(seq[i]);
    bus.finish = 1'b1;
    step(2'd2);
    checks++;
    if ({bus.finished, bus.loop_active, bus.loop_done} !== 3'b100 || bus.iter_count !== 32'd2) begin
      errors++;
      $display("FAIL finish_enter fin,la,ld %b cnt %0d exp 100 2",
               {bus.finished, bus.loop_active, bus.loop_done}, bus.iter_count);
    end
    bus.finish = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(post[i]);
      checks++;
      if ({bus.finished, bus.loop_active, bus.loop_done} !== 3'b100 ||
          bus.iter_count !== 32'd2 || bus.trip_count !== 32'd0) begin
        errors++;
        $display("FAIL finish_frozen step %0d fin,la,ld %b cnt %0d trip %0d exp 100 2 0", i,
                 {bus.finished, bus.loop_active, bus.loop_done}, bus.iter_count, bus.trip_count);
      end
    end
    apply_reset(1);
    checks++;
    if (bus.finished !== 1'b0) begin
      errors++;
      $display("FAIL finish_reset got %b exp 0", bus.finished);
    end
  endtask

  task automatic test_reset_mid_loop();
    logic [1:0] part [6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    logic [1:0] full [8] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    cfg_multi();
    apply_reset(1);
    for (int i = 0; i < 6; i++) step(part[i]);
    checks++;
    if (bus.iter_count !== 32'd2 || bus.loop_active !== 1'b1) begin
      errors++;
      $display("FAIL midloop_pre cnt %0d la %b exp 2 1", bus.iter_count, bus.loop_active);
    end
    apply_reset(1);
    checks++;
    if (bus.iter_count !== 32'd0 || bus.loop_active !== 1'b0) begin
      errors++;
      $display("FAIL midloop_reset cnt %0d la %b exp 0 0", bus.iter_count, bus.loop_active);
    end
    for (int i = 0; i < 8; i++) step(full[i]);
    checks++;
    if (bus.loop_done !== 1'b1 || bus.trip_count !== 32'd3) begin
      errors++;
      $display("FAIL midloop_rerun ld %b trip %0d exp 1 3", bus.loop_done, bus.trip_count);
    end
  endtask

  initial begin
    test_reset();
    test_multi_state();
    test_single_state();
    test_back_to_back();
    test_quit_filter();
    test_hang();
    test_finish();
    test_reset_mid_loop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
